// File: rtl/store_write_buffer_pkg.sv
// Shared store-buffer types: store kinds, the queued entry format and the store fault code.
// Entries hold a word-aligned address so the head can drive the SRAM port directly.
package store_buffer_params;

  localparam logic [5:0] STORE_ADDRESS_ERROR = 6'h05;

  typedef enum logic [2:0] {
    STORE_BYTE  = 3'd0,
    STORE_HALF  = 3'd1,
    STORE_WORD  = 3'd2,
    STORE_LEFT  = 3'd3,
    STORE_RIGHT = 3'd4
  } StoreKind;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  strobe;
    logic [31:0] data;
  } StoreEntry;

endpackage

// File: rtl/store_write_buffer_if.sv
// Store-side and SRAM-side signals of the store write buffer; slave is the buffer, master the environment.
// Handshakes are valid/ready on both sides; fault and query outputs are combinational.
interface store_write_buffer_if;
  import store_buffer_params::*;

  logic        store_valid;
  logic        store_ready;
  StoreKind    store_kind;
  logic [31:0] store_address;
  logic [31:0] store_data;
  logic        address_exception;
  logic [5:0]  exception_code;
  logic        data_ram_enable;
  logic        data_ram_ready;
  logic [31:0] data_ram_address;
  logic [3:0]  data_ram_write_strobe;
  logic [31:0] data_ram_write_data;
  logic [31:0] query_address;
  logic        query_hit;
  logic        buffer_empty;

  modport slave (
    input  store_valid, store_kind, store_address, store_data, data_ram_ready, query_address,
    output store_ready, address_exception, exception_code, data_ram_enable, data_ram_address,
           data_ram_write_strobe, data_ram_write_data, query_hit, buffer_empty
  );

  modport master (
    output store_valid, store_kind, store_address, store_data, data_ram_ready, query_address,
    input  store_ready, address_exception, exception_code, data_ram_enable, data_ram_address,
           data_ram_write_strobe, data_ram_write_data, query_hit, buffer_empty
  );

endinterface

// File: rtl/store_write_buffer_fifo.sv
// In-order DEPTH-entry FIFO of StoreEntry; head visible one edge after push, no pass-through.
// Push ignored when full, pop ignored when empty; per-entry valid bits and word addresses exported.
module store_fifo
  import store_buffer_params::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  StoreEntry              entry_i,
  input  logic                   pop_i,
  output StoreEntry              head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       entry_valid_o,
  output logic [DEPTH-1:0][29:0] entry_addr_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  StoreEntry     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  // Slot i is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PW-1:0] off;
    assign off              = PW'(i) - rd_ptr_q;
    assign entry_valid_o[i] = ({1'b0, off} < count_q);
    assign entry_addr_o[i]  = mem_q[i].address[31:2];
  end

endmodule

// File: rtl/store_write_buffer.sv
// Formats committed stores into strobes/lane data and queues them for the SRAM; one edge to head.
// store_ready is !full (no pass-through when full); head holds until data_ram_ready; faults drop the store.
module store_write_buffer
  import store_buffer_params::*;
#(
  parameter int DEPTH          = 4,
  parameter int CPU_DATA_WIDTH = 32
) (
  input logic                 clock,
  input logic                 reset,
  store_write_buffer_if.slave bus
);

  if (CPU_DATA_WIDTH != 32) begin : g_width_unsupported
    $error("store_write_buffer supports only a 32-bit datapath");
  end

  logic [1:0]            a;
  logic [31:0]           rt;
  logic                  fault;
  logic [3:0]            strobe;
  logic [31:0]           wdata;
  logic                  push, pop, full, empty, hit;
  StoreEntry             new_entry, head;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][29:0] entry_addr;
  logic                  unused_query_lsbs;

  assign a  = bus.store_address[1:0];
  assign rt = bus.store_data;

  always_comb begin
    fault  = 1'b0;
    strobe = 4'b0000;
    wdata  = '0;
    case (bus.store_kind)
      STORE_BYTE: begin
        strobe = 4'b0001 << a;
        wdata  = {4{rt[7:0]}};
      end
      STORE_HALF: begin
        fault  = a[0];
        strobe = a[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{rt[15:0]}};
      end
      STORE_WORD: begin
        fault  = (a != 2'b00);
        strobe = 4'b1111;
        wdata  = rt;
      end
      // Unaligned left/right halves: SWL fills lanes 0..a from the top of rt, SWR fills a..3 from the bottom.
      STORE_LEFT: begin
        strobe = 4'b1111 >> (2'd3 - a);
        wdata  = rt >> {(2'd3 - a), 3'b000};
      end
      STORE_RIGHT: begin
        strobe = 4'b1111 << a;
        wdata  = rt << {a, 3'b000};
      end
      default: ;
    endcase
  end

  assign new_entry = '{address: {bus.store_address[31:2], 2'b00}, strobe: strobe, data: wdata};
  assign push      = bus.store_valid && !full && !fault;
  assign pop       = !empty && bus.data_ram_ready;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock         (clock),
    .reset         (reset),
    .push_i        (push),
    .entry_i       (new_entry),
    .pop_i         (pop),
    .head_o        (head),
    .full_o        (full),
    .empty_o       (empty),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == bus.query_address[31:2])) hit = 1'b1;
    end
  end

  assign unused_query_lsbs         = ^bus.query_address[1:0];
  assign bus.store_ready           = !full;
  assign bus.address_exception     = bus.store_valid && fault;
  assign bus.exception_code        = bus.address_exception ? STORE_ADDRESS_ERROR : 6'h00;
  assign bus.data_ram_enable       = !empty;
  assign bus.data_ram_address      = head.address;
  assign bus.data_ram_write_strobe = head.strobe;
  assign bus.data_ram_write_data   = head.data;
  assign bus.query_hit             = hit;
  assign bus.buffer_empty          = empty;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: byte-lane reference model over a queue, directed cases then random traffic.
module tb_store_write_buffer;
  import store_buffer_params::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  store_write_buffer_if bus();

  store_write_buffer #(.DEPTH(DEPTH), .CPU_DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    logic [31:0] s;
    s = w >> (8 * k);
    return s[7:0];
  endfunction

  // Reference formatting built lane by lane from which memory bytes each store writes.
  function automatic exp_t fmt(input StoreKind kind, input logic [31:0] addr,
                               input logic [31:0] rt, output bit fault);
    exp_t e;
    int   off;
    off    = int'(addr[1:0]);
    fault  = 1'b0;
    e.addr = {addr[31:2], 2'b00};
    e.strb = 4'b0000;
    e.data = '0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] lane;
      lane = 8'h00;
      case (kind)
        STORE_BYTE: begin e.strb[k] = (k == off); lane = byte_of(rt, 0); end
        STORE_HALF: begin e.strb[k] = (k / 2 == off / 2); lane = byte_of(rt, k % 2); fault = (off % 2 != 0); end
        STORE_WORD: begin e.strb[k] = 1'b1; lane = byte_of(rt, k); fault = (off != 0); end
        STORE_LEFT: begin e.strb[k] = (k <= off); lane = (k <= off) ? byte_of(rt, k + 3 - off) : 8'h00; end
        STORE_RIGHT: begin e.strb[k] = (k >= off); lane = (k >= off) ? byte_of(rt, k - off) : 8'h00; end
        default: ;
      endcase
      e.data = e.data | ({24'h0, lane} << (8 * k));
    end
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    bit   f;
    bit   exp_hit;
    e = fmt(bus.store_kind, bus.store_address, bus.store_data, f);
    exp_hit = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == bus.query_address[31:2]) exp_hit = 1'b1;
    chk("store_ready", {31'b0, bus.store_ready}, {31'b0, q.size() < DEPTH});
    chk("address_exception", {31'b0, bus.address_exception}, {31'b0, bus.store_valid && f});
    chk("exception_code", {26'b0, bus.exception_code}, (bus.store_valid && f) ? 32'h5 : 32'h0);
    chk("data_ram_enable", {31'b0, bus.data_ram_enable}, {31'b0, q.size() > 0});
    chk("buffer_empty", {31'b0, bus.buffer_empty}, {31'b0, q.size() == 0});
    chk("query_hit", {31'b0, bus.query_hit}, {31'b0, exp_hit});
    if (q.size() > 0) begin
      chk("head_address", bus.data_ram_address, q[0].addr);
      chk("head_strobe", {28'b0, bus.data_ram_write_strobe}, {28'b0, q[0].strb});
      chk("head_data", bus.data_ram_write_data, q[0].data);
    end
  endtask

  task automatic drive(input logic v, input StoreKind k, input logic [31:0] a,
                       input logic [31:0] d, input logic r, input logic [31:0] qa);
    bus.store_valid    = v;
    bus.store_kind     = k;
    bus.store_address  = a;
    bus.store_data     = d;
    bus.data_ram_ready = r;
    bus.query_address  = qa;
  endtask

  // Called at a falling edge with inputs applied; checks, advances the model across the rising edge.
  task automatic step();
    exp_t e;
    bit   f;
    bit   do_push, do_pop;
    #1;
    check_outputs();
    @(posedge clock);
    e       = fmt(bus.store_kind, bus.store_address, bus.store_data, f);
    do_pop  = (q.size() > 0) && bus.data_ram_ready;
    do_push = bus.store_valid && (q.size() < DEPTH) && !f;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("reset_enable", {31'b0, bus.data_ram_enable}, 32'h0);
    chk("reset_empty", {31'b0, bus.buffer_empty}, 32'h1);
    chk("reset_ready", {31'b0, bus.store_ready}, 32'h1);
    chk("reset_hit", {31'b0, bus.query_hit}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    drive(1'b1, STORE_BYTE, 32'h1003, 32'h11223344, 1'b0, 32'h0);
    step();
    chk("sb_addr", bus.data_ram_address, 32'h1000);
    chk("sb_strobe", {28'b0, bus.data_ram_write_strobe}, 32'h8);
    chk("sb_data", bus.data_ram_write_data, 32'h44444444);

    drive(1'b1, STORE_LEFT, 32'h2001, 32'hAABBCCDD, 1'b1, 32'h0);
    step();
    chk("swl_strobe", {28'b0, bus.data_ram_write_strobe}, 32'h3);
    chk("swl_data", bus.data_ram_write_data, 32'h0000AABB);

    drive(1'b1, STORE_RIGHT, 32'h2001, 32'hAABBCCDD, 1'b1, 32'h0);
    step();
    chk("swr_strobe", {28'b0, bus.data_ram_write_strobe}, 32'hE);
    chk("swr_data", bus.data_ram_write_data, 32'hBBCCDD00);

    drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b1, 32'h0);
    step();
    chk("drained_empty", {31'b0, bus.buffer_empty}, 32'h1);

    drive(1'b1, STORE_HALF, 32'h3001, 32'h12345678, 1'b1, 32'h0);
    #1;
    chk("sh_fault", {31'b0, bus.address_exception}, 32'h1);
    chk("sh_code", {26'b0, bus.exception_code}, 32'h5);
    step();
    chk("sh_not_queued", {31'b0, bus.buffer_empty}, 32'h1);

    drive(1'b1, STORE_WORD, 32'h3002, 32'h12345678, 1'b1, 32'h0);
    #1;
    chk("sw_fault", {31'b0, bus.address_exception}, 32'h1);
    chk("sw_code", {26'b0, bus.exception_code}, 32'h5);
    step();
    chk("sw_not_queued", {31'b0, bus.buffer_empty}, 32'h1);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, STORE_WORD, 32'h5000 + 32'(4 * i), 32'(i), 1'b0, 32'h0);
      step();
    end
    chk("full_ready_low", {31'b0, bus.store_ready}, 32'h0);
    drive(1'b1, STORE_WORD, 32'h5100, 32'hDEAD, 1'b1, 32'h0);
    #1;
    chk("full_ready_low_on_pop", {31'b0, bus.store_ready}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b1, 32'h0);
      #1;
      chk("drain_order", bus.data_ram_address, 32'h5000 + 32'(4 * i));
      step();
    end
    chk("drain_done", {31'b0, bus.buffer_empty}, 32'h1);

    drive(1'b1, STORE_WORD, 32'h6000, 32'h0, 1'b0, 32'h0); step();
    drive(1'b1, STORE_WORD, 32'h6004, 32'h0, 1'b0, 32'h0); step();
    drive(1'b1, STORE_WORD, 32'h6008, 32'h0, 1'b1, 32'h0); step();
    drive(1'b1, STORE_WORD, 32'h600C, 32'h0, 1'b0, 32'h0); step();
    chk("pushpop_three_ready", {31'b0, bus.store_ready}, 32'h1);
    drive(1'b1, STORE_WORD, 32'h6010, 32'h0, 1'b0, 32'h0); step();
    chk("pushpop_four_full", {31'b0, bus.store_ready}, 32'h0);
    chk("pushpop_head", bus.data_ram_address, 32'h6004);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b1, 32'h0);
      step();
    end

    drive(1'b1, STORE_WORD, 32'h4004, 32'h99, 1'b0, 32'h4004);
    #1;
    chk("query_push_invisible", {31'b0, bus.query_hit}, 32'h0);
    step();
    drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b0, 32'h4006);
    #1;
    chk("query_hit_same_word", {31'b0, bus.query_hit}, 32'h1);
    drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b0, 32'h4008);
    #1;
    chk("query_miss_next_word", {31'b0, bus.query_hit}, 32'h0);
    drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b1, 32'h4006);
    #1;
    chk("query_hit_during_pop", {31'b0, bus.query_hit}, 32'h1);
    step();
    #1;
    chk("query_clear_after_pop", {31'b0, bus.query_hit}, 32'h0);

    drive(1'b1, STORE_WORD, 32'h8000, 32'h1, 1'b0, 32'h8000); step();
    drive(1'b1, STORE_WORD, 32'h8004, 32'h2, 1'b0, 32'h8000); step();
    drive(1'b0, STORE_WORD, 32'h0, 32'h0, 1'b0, 32'h8000);
    #1;
    chk("pre_reset_hit", {31'b0, bus.query_hit}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_enable", {31'b0, bus.data_ram_enable}, 32'h0);
    chk("async_reset_empty", {31'b0, bus.buffer_empty}, 32'h1);
    chk("async_reset_ready", {31'b0, bus.store_ready}, 32'h1);
    chk("async_reset_hit", {31'b0, bus.query_hit}, 32'h0);
    q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 2) != 0), StoreKind'(3'($urandom_range(0, 4))),
            32'h9000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
            $urandom(), ($urandom_range(0, 1) == 1),
            32'h9000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Committed-store path between the writeback stage and the data SRAM write port, the write-side counterpart of the load alignment logic in the memory-access stage. It accepts one store per cycle (SB/SH/SW/SWL/SWR) and formats byte strobes and lane-replicated write data. Each store is queued in a small in-order FIFO and drained to the SRAM under a valid/ready handshake. It also reports store address faults and flags pending stores that overlap a load's word, so the load path can stall.

## Interface
- `DEPTH`, 4, number of buffered stores; power of two, ≥2.
- `CPU_DATA_WIDTH`, 32, data and address width; only 32 is supported.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `store_valid` in 1: committed store offered.
- `store_ready` out 1: buffer can accept a store (`!full`).
- `store_kind` in 3: `STORE_BYTE`, `STORE_HALF`, `STORE_WORD`, `STORE_LEFT`, `STORE_RIGHT`.
- `store_address` in 32: byte address.
- `store_data` in 32: rt register value.
- `address_exception` out 1: combinational; misaligned SH/SW while `store_valid`.
- `exception_code` out 6: 6'h05 (AdES) when `address_exception`, else 0.
- `data_ram_enable` out 1: head entry valid.
- `data_ram_ready` in 1: SRAM accepts head this cycle.
- `data_ram_address` out 32: word-aligned head address `{addr[31:2],2'b00}`.
- `data_ram_write_strobe` out 4: head byte strobes.
- `data_ram_write_data` out 32: head write data.
- `query_address` in 32: load address from EX.
- `query_hit` out 1: any valid entry with equal `addr[31:2]`.
- `buffer_empty` out 1: no valid entries.

## Operation
- Push when `store_valid && store_ready && !address_exception`. A faulting store is dropped and nothing is queued; the fault pulse is the caller's responsibility to consume.
- Fault rules: `STORE_HALF` with `addr[0]!=0`, and `STORE_WORD` with `addr[1:0]!=0`. Byte, left and right stores never fault.
- Formatting, with `a = addr[1:0]`, little-endian:
  - SB: strobe `4'b0001<<a`; data `{4{rt[7:0]}}`.
  - SH: strobe `a[1] ? 1100 : 0011`; data `{2{rt[15:0]}}`.
  - SW: strobe 1111; data rt.
  - SWL: a=0 → 0001, `rt>>24`; a=1 → 0011, `rt>>16`; a=2 → 0111, `rt>>8`; a=3 → 1111, rt.
  - SWR: a=0 → 1111, rt; a=1 → 1110, `rt<<8`; a=2 → 1100, `rt<<16`; a=3 → 1000, `rt<<24`.
- Pop when `data_ram_enable && data_ram_ready`. Head outputs hold stable until popped. Strict FIFO order.
- `query_hit` is combinational over all valid entries. A same-cycle push is not visible to it; a same-cycle pop is still visible to it.

## Timing
- Reset values: `data_ram_enable`=0, `buffer_empty`=1, `store_ready`=1, `query_hit`=0. Pointers and count are 0; entry payloads are don't-care.
- Latency: a store pushed at edge N appears on `data_ram_*` after edge N when the buffer was empty. Data does not pass through combinationally.
- Pointers wrap modulo DEPTH. Count has width log2(DEPTH)+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: `store_ready`=0 even if a pop occurs the same cycle; there is no pass-through.
- Empty: `data_ram_enable`=0 and address/strobe/data are don't-care.
- Reset asserted mid-drain: all entries are discarded immediately and outputs return to their reset values asynchronously.

## Structure
- Shared package `store_buffer_params`: `StoreKind` enum, `StoreEntry` struct (address[31:0], strobe[3:0], data[31:0]), and constant `STORE_ADDRESS_ERROR = 6'h05`.
- Sub-module `store_fifo`: a generic DEPTH-entry FIFO of `StoreEntry` with push/pop and full/empty. It exposes the valid bits and addresses of every entry for the query compare.
- Formatting, fault detection and query compare live in the top as combinational logic.

## Test plan
- Reset with 2 entries queued → `data_ram_enable`=0, `buffer_empty`=1, `store_ready`=1 immediately, with no clock edge required.
- SB, addr 0x1003, rt 0x11223344 → next cycle `data_ram_address`=0x1000, strobe 1000, data 0x44444444.
- SWL, addr 0x2001, rt 0xAABBCCDD → strobe 0011, data 0x0000AABB.
- SWR, same address and rt → strobe 1110, data 0xBBCCDD00.
- SH, addr 0x3001 → `address_exception`=1, `exception_code`=0x05, nothing queued, `buffer_empty` stays 1.
- SW, addr 0x3002 → same fault response.
- Hold `data_ram_ready`=0 and push 4 SWs → `store_ready`=0 after the 4th.
- Then raise ready → entries drain in order, one per cycle.
- Push and pop in the same cycle with 2 entries queued → count stays 2.
- SW queued at 0x4004 → `query_address` 0x4006 gives `query_hit`=1; 0x4008 gives 0.
- `query_hit` drops the cycle after that entry pops.
